// File: rtl/vp_pkg.sv
// vp_pkg: shared state encoding and width helpers for the vertex transform sequencer
package vp_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, DONE} state_t;
  localparam int VP_M = 11;
  localparam int VP_N = 7;
  function automatic int prod_w(input int m, input int n);
    return 2 * (m + n);
  endfunction
  function automatic int acc_w(input int m, input int n);
    return prod_w(m, n) + 3;
  endfunction
  function automatic int one_q(input int n);
    return 1 << n;
  endfunction
  localparam int VP_ONE = one_q(VP_N);
endpackage

// File: rtl/vp_mac_unit.sv
// vp_mac_unit: signed multiply-accumulate with clear-on-first-term and scaled result tap
module vp_mac_unit import vp_pkg::*; #(
  parameter int M = VP_M,
  parameter int N = VP_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic signed [M+N-1:0] a,
  input  logic signed [M+N-1:0] b,
  output logic [M-1:0]       res
);
  localparam int PW = prod_w(M, N);
  localparam int AW = acc_w(M, N);
  logic signed [AW-1:0] acc, sum;
  logic signed [PW-1:0] prod;
  // next accumulator value; res is the Q-format integer part of it, truncated
  always_comb begin
    prod = PW'(a) * PW'(b);
    sum = (clr ? '0 : acc) + AW'(prod);
    res = sum[2*N +: M];
  end
  // accumulator register
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/vp_transform_sequencer.sv
// vp_transform_sequencer: streams vertices through a 4x4 fixed-point matrix using one shared MAC
module vp_transform_sequencer import vp_pkg::*; #(
  parameter int M = VP_M,
  parameter int N = VP_N,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_idx,
  input  logic signed [M+N-1:0] cfg_data,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_in,
  input  logic [ADDR_W-1:0]     base_out,
  input  logic [ADDR_W-3:0]     vertex_count,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [M+N-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [M-1:0]          wr_data
);
  localparam int W = M + N;
  localparam logic signed [W-1:0] ONE = W'(one_q(N));
  state_t state, nxt;
  logic [3:0] cnt;
  logic [ADDR_W-3:0] vleft;
  logic [ADDR_W-1:0] in_ptr, out_ptr;
  logic cap;
  logic [1:0] cap_k;
  logic signed [W-1:0] mat [16];
  logic signed [W-1:0] vtx [4];
  logic [M-1:0] res;
  logic mac_en, row_end, last;
  // next state and state-decoded outputs
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (vertex_count == '0 ? DONE : FETCH) : IDLE;
      FETCH: nxt = cnt[1:0] == 2'd3 ? WAIT : FETCH;
      WAIT:  nxt = MAC;
      MAC:   nxt = cnt == 4'd15 ? (vleft == (ADDR_W-2)'(1) ? DONE : FETCH) : MAC;
      default: nxt = IDLE;
    endcase
    busy = state != IDLE;
    done = state == DONE;
    rd_en = state == FETCH;
    rd_addr = rd_en ? in_ptr + ADDR_W'(cnt[1:0]) : '0;
    mac_en = state == MAC;
    row_end = mac_en && cnt[1:0] == 2'd3;
    last = mac_en && cnt == 4'd15;
  end
  // state, phase counter and per-vertex address pointers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      vleft <= '0;
      in_ptr <= '0;
      out_ptr <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 4'd1;
      if (state == IDLE && start) begin
        in_ptr <= base_in;
        out_ptr <= base_out;
        vleft <= vertex_count;
      end else if (last) begin
        in_ptr <= in_ptr + ADDR_W'(4);
        out_ptr <= out_ptr + ADDR_W'(4);
        vleft <= vleft - (ADDR_W-2)'(1);
      end
    end
  // capture read data one cycle after each fetch request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap <= 1'b0;
      cap_k <= '0;
      for (int i = 0; i < 4; i++) vtx[i] <= '0;
    end else begin
      cap <= rd_en;
      cap_k <= cnt[1:0];
      if (cap) vtx[cap_k] <= rd_data;
    end
  // matrix register file, identity on reset, writable only while idle
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 16; i++) mat[i] <= (i % 5 == 0) ? ONE : '0;
    else if (state == IDLE && cfg_we) mat[cfg_idx] <= cfg_data;
  // registered write port, one row result per four MAC cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= row_end;
      if (row_end) begin
        wr_addr <= out_ptr + ADDR_W'(cnt[3:2]);
        wr_data <= res;
      end
    end
  vp_mac_unit #(.M(M), .N(N)) u_mac (
    .clk(clk),
    .rst(rst),
    .en(mac_en),
    .clr(cnt[1:0] == 2'd0),
    .a(mat[cnt]),
    .b(vtx[cnt[1:0]]),
    .res(res)
  );
endmodule

// File: tb/tb_vp_transform_sequencer.sv
// tb_vp_transform_sequencer: randomized batches checked against a matrix-times-vector reference
module tb_vp_transform_sequencer;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0;
  logic [3:0] cfg_idx = '0;
  logic signed [17:0] cfg_data = '0, rd_data = '0;
  logic [15:0] base_in = '0, base_out = '0;
  logic [13:0] vertex_count = '0;
  logic busy, done, rd_en, wr_en;
  logic [15:0] rd_addr, wr_addr;
  logic [10:0] wr_data;
  logic signed [17:0] mem [65536];
  logic signed [17:0] mmat [16];
  int total = 0, bad = 0;

  vp_transform_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start(start), .base_in(base_in), .base_out(base_out), .vertex_count(vertex_count),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_row(input logic [15:0] bi, input int v, input int n);
    longint s = 0;
    for (int m = 0; m < 4; m++)
      s += longint'(mmat[4*n+m]) * longint'(mem[16'(bi + 16'(4*v+m))]);
    return (s >>> 14) & 64'h7FF;
  endfunction

  task automatic model_ident();
    for (int i = 0; i < 16; i++) mmat[i] = (i % 5 == 0) ? 18'sd128 : 18'sd0;
  endtask

  task automatic set_mat(input int i, input logic signed [17:0] val);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 4'(i); cfg_data = val; mmat[i] = val;
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic load_diag(input logic signed [17:0] val);
    for (int i = 0; i < 16; i++) set_mat(i, (i % 5 == 0) ? val : 18'sd0);
  endtask

  task automatic fill_rand(input logic [15:0] bi, input int nv);
    for (int j = 0; j < 4*nv; j++) mem[16'(bi + 16'(j))] = 18'($urandom);
  endtask

  task automatic run_batch(input logic [15:0] bi, input logic [15:0] bo, input int nv, input bit poke);
    int done_t = -1, nw = 0, nr = 0, v, k;
    @(negedge clk);
    base_in = bi; base_out = bo; vertex_count = 14'(nv); start = 1;
    for (int t = 1; t <= 21*nv + 10 && done_t < 0; t++) begin
      @(negedge clk);
      if (t == 1) start = 0;
      if (poke && t == 8) begin cfg_we = 1; cfg_idx = 4'd15; cfg_data = 18'h1555; start = 1; end
      if (poke && t == 9) begin cfg_we = 0; start = 0; end
      check("busy_in_batch", busy, 1);
      if (rd_en) begin
        v = nr / 4; k = nr % 4;
        check("rd_addr", rd_addr, 16'(bi + 16'(4*v+k)));
        check("rd_cycle", t, 21*v + 1 + k);
        nr++;
      end
      if (wr_en) begin
        v = nw / 4; k = nw % 4;
        check("wr_addr", wr_addr, 16'(bo + 16'(4*v+k)));
        check("wr_data", wr_data, exp_row(bi, v, k));
        check("wr_cycle", t, 21*v + 10 + 4*k);
        nw++;
      end
      if (done) done_t = t;
    end
    check("done_cycle", done_t, nv == 0 ? 1 : 21*nv + 1);
    check("write_count", nw, 4*nv);
    check("read_count", nr, 4*nv);
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
  endtask

  initial begin
    model_ident();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 0;
    mem[0] = 128; mem[1] = 256; mem[2] = -384; mem[3] = 128;
    run_batch(16'h0000, 16'h0100, 1, 0);
    set_mat(3, 640); set_mat(7, -256); set_mat(11, 0);
    mem[16] = 128; mem[17] = 256; mem[18] = 384; mem[19] = 128;
    run_batch(16'h0010, 16'h0200, 1, 0);
    run_batch(16'h0040, 16'h0080, 0, 0);
    load_diag(256);
    fill_rand(16'hFFFC, 3);
    run_batch(16'hFFFC, 16'hFFF8, 3, 0);
    load_diag(128);
    set_mat(0, 128000);
    mem[16'h0300] = 256; mem[16'h0301] = 0; mem[16'h0302] = 0; mem[16'h0303] = 128;
    run_batch(16'h0300, 16'h0400, 1, 0);
    for (int r = 0; r < 6; r++) begin
      logic [15:0] bi, bo;
      int nv;
      for (int i = 0; i < 16; i++) set_mat(i, 18'($urandom));
      bi = 16'($urandom); bo = 16'($urandom); nv = $urandom_range(1, 3);
      fill_rand(bi, nv);
      run_batch(bi, bo, nv, r % 2 == 1);
    end
    mem[0] = 128; mem[1] = 256; mem[2] = -384; mem[3] = 128;
    @(negedge clk);
    base_in = 16'h0000; base_out = 16'h0500; vertex_count = 14'd1; start = 1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) start = 0;
    end
    check("pre_rst_wr_en", wr_en, 1);
    rst = 1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_done", done, 0);
    model_ident();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 2) rst = 0;
      check("post_rst_wr_en", wr_en, 0);
    end
    run_batch(16'h0000, 16'h0600, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
